k16_fb_arbiter: RTL and testbench
=================================

Name: k16_fb_arbiter

Overview:
Owns the 2048x16 text/colour frame buffer RAM and arbitrates its single port between the video scan-out stage and the CPU bus. The video stage is the downstream consumer: it issues read strobes, gets absolute priority, and receives a held data word. CPU writes are posted through a 4-entry FIFO. CPU reads stall until the FIFO has drained and the port is free, so CPU ordering is preserved.

Parameters:
ADDR_W, 11, frame buffer address width (2048 words; 40x30 cells use 0..1199)
DATA_W, 16, word width (bit15 mode, [13:8] colours, [7:0] char)
WFIFO_DEPTH, 4, posted-write FIFO entries (power of two)

Ports:
clk  in  1  system clock (pixel clock domain)
reset  in  1  asynchronous, active-low reset
vid_req  in  1  video read strobe (want_read_frame_buffer), held 2 cycles per cell
vid_addr  in  ADDR_W  video read address, valid while vid_req=1
vid_data  out  DATA_W  last video read result, held until next video read completes
cpu_req  in  1  CPU access request, held until cpu_ready=1
cpu_we  in  1  1=write, 0=read; stable while cpu_req=1
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid when cpu_ready=1 and cpu_we=0
cpu_ready  out  1  access accepted/completed this cycle
wfifo_level  out  3  current FIFO occupancy 0..4 (debug/status)

Behaviour:
- Reset (reset=0, async): vid_data=0, cpu_rdata=0, cpu_ready=0, wfifo_level=0, FIFO pointers cleared (pending writes discarded), read FSM=IDLE. RAM contents not cleared.
- RAM: single port, synchronous read, 1-cycle latency, write-first disabled (read returns old data).
- Port priority per cycle: (1) vid_req=1 -> RAM addr=vid_addr, read; (2) read FSM in ISSUE -> RAM addr=cpu_addr, read; (3) FIFO non-empty -> pop head, write RAM.
- Video path: cycle N with vid_req=1 -> vid_data updated at edge N+1 with RAM[vid_addr at N]. Second strobe cycle rereads the same address; vid_data is therefore valid no later than 2 edges after the first strobe and remains valid through the third. vid_data never changes while vid_req=0.
- CPU write: cpu_ready = cpu_req & cpu_we & !full, combinational. Push occurs on that edge. When full, no push even if a pop occurs in the same cycle; ready rises the following cycle.
- Simultaneous push+pop (not full): level unchanged; the FIFO stays ordered.
- CPU read FSM: IDLE -(cpu_req & !cpu_we)-> DRAIN; DRAIN -(FIFO empty)-> ISSUE; ISSUE -(!vid_req, RAM read issued)-> DATA; DATA: cpu_rdata registered, cpu_ready=1 for exactly one cycle -> IDLE. A read after a write to the same address returns the written data.
- cpu_ready for reads is registered. The earliest read latency is 3 cycles (req at IDLE, empty FIFO, no video).
- If cpu_req drops in DRAIN/ISSUE (protocol violation), the FSM completes anyway and the result is discarded.
- Address arithmetic: no wrap logic. Any address 0..2047 is legal.
- Video reads are at most 2 of every 16 cycles, so the FIFO always drains. There is no starvation case.

Decomposition:
- Shared package k16_fb_pkg: FB_ADDR_W=11, FB_DATA_W=16, FB_COLUMNS=40, FB_ROWS=30, read-FSM state enum (IDLE, DRAIN, ISSUE, DATA).
- Sub-module k16_fb_ram: single-port synchronous 2048x16 RAM (clk, addr, we, wdata, rdata), inferred as FPGA block RAM.
- The FIFO is inline (4 entries, 3-bit count, 2-bit pointers).

Test Plan:
- Reset with cpu write queued (level=2) -> level=0, cpu_ready=0, vid_data=0, FSM IDLE, queued writes never reach RAM.
- CPU writes 0x0741 to addr 5, then video vid_req for 2 cycles at addr 5 -> vid_data=0x0741 within 2 edges and held 14 cycles.
- Four back-to-back writes while vid_req held high -> ready 4 cycles, level=4. A fifth write gets cpu_ready=0 until vid_req drops and one pop occurs.
- Write 0xBEEF to addr 1199, then immediate read of 1199 -> FSM passes DRAIN, cpu_rdata=0xBEEF, cpu_ready=1 for exactly 1 cycle.
- Read issued while vid_req=1 for 2 cycles -> ISSUE stalls 2 cycles, video gets correct data, CPU read completes 2 cycles later.
- Full FIFO with simultaneous pop and new write request -> no push that cycle, level 4->3, push on the next edge, level back to 4, RAM write order preserved.

Source files
------------

// File: rtl/k16_fb_pkg.sv
// Shared constants and types for the k16 text/colour frame buffer.
// The frame buffer stores 40x30 cells in the low 1200 words of a 2048-word RAM.
package k16_fb_pkg;

  localparam int FB_ADDR_W  = 11;
  localparam int FB_DATA_W  = 16;
  localparam int FB_COLUMNS = 40;
  localparam int FB_ROWS    = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2,
    DATA  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/k16_fb_ram.sv
// Single-port synchronous frame buffer RAM with a one-cycle read latency.
// A write returns the previous contents on rdata, which maps onto FPGA block RAM.
module k16_fb_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/k16_fb_arbiter.sv
// Frame buffer port arbiter: video reads win outright, CPU reads wait for the
// posted-write FIFO to drain, and queued CPU writes fill the remaining cycles.
module k16_fb_arbiter
  import k16_fb_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic [2:0]        wfifo_level
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = WFIFO_DEPTH[PTR_W:0];

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  rd_state_t         state;
  rd_state_t         state_next;
  logic              read_done;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_hold;
  logic [DATA_W-1:0] cpu_rdata_q;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign push      = cpu_req & cpu_we & ~full;
  assign read_done = (state == DATA) & cpu_req & ~cpu_we;
  assign cpu_ready = push | read_done;
  assign wfifo_level = 3'(count);

  // One owner per cycle: video strobe, then a pending CPU read, then a FIFO pop.
  always_comb begin
    ram_addr  = vid_addr;
    ram_we    = 1'b0;
    ram_wdata = fifo_data[rd_ptr];
    pop       = 1'b0;
    if (vid_req) begin
      ram_addr = vid_addr;
    end else if (state == ISSUE) begin
      ram_addr = cpu_addr;
    end else if (!empty) begin
      ram_addr = fifo_addr[rd_ptr];
      ram_we   = 1'b1;
      pop      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Reads run to completion even if the request is withdrawn part way.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu_req && !cpu_we) state_next = DRAIN;
      DRAIN:   if (empty)              state_next = ISSUE;
      ISSUE:   if (!vid_req)           state_next = DATA;
      DATA:                            state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // RAM output is shown directly in the cycle it arrives, then held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_valid_q <= 1'b0;
      vid_hold    <= '0;
      cpu_rdata_q <= '0;
    end else begin
      vid_valid_q <= vid_req;
      if (vid_valid_q) begin
        vid_hold <= ram_rdata;
      end
      if (read_done) begin
        cpu_rdata_q <= ram_rdata;
      end
    end
  end

  assign vid_data  = vid_valid_q ? ram_rdata : vid_hold;
  assign cpu_rdata = read_done ? ram_rdata : cpu_rdata_q;

  k16_fb_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_k16_fb_arbiter.sv
// Testbench for k16_fb_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based model of the frame buffer and write FIFO.
module tb_k16_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vid_req = 1'b0;
  logic [10:0] vid_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] vid_data;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic [2:0]  wfifo_level;

  int vectors = 0;
  int miscompares = 0;

  k16_fb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .wfifo_level (wfifo_level)
  );

  always #5 clk = ~clk;

  // Reference model: RAM image, queue of posted writes, CPU read progress.
  logic [15:0] m_ram [2048];
  logic [10:0] q_addr [$];
  logic [15:0] q_data [$];
  int          m_rd;
  logic [15:0] m_vid;
  logic [15:0] m_rdata;
  logic [15:0] m_rdval;

  logic        e_ready;
  logic        e_wr_acc;
  logic        e_rd_done;
  logic [2:0]  e_level;
  logic [15:0] e_vid;
  logic [15:0] e_rdata;

  task automatic model_reset();
    q_addr.delete();
    q_data.delete();
    m_rd    = 0;
    m_vid   = '0;
    m_rdata = '0;
    m_rdval = '0;
  endtask

  task automatic settle();
    @(negedge clk);
    e_level   = 3'(q_addr.size());
    e_wr_acc  = cpu_req && cpu_we && (q_addr.size() < 4);
    e_rd_done = (m_rd == 3) && cpu_req && !cpu_we;
    e_ready   = e_wr_acc || e_rd_done;
    e_vid     = m_vid;
    e_rdata   = e_rd_done ? m_rdval : m_rdata;
  endtask

  task automatic advance();
    bit q_empty;
    int next_rd;
    if (!reset) begin
      model_reset();
    end else begin
      q_empty = (q_addr.size() == 0);
      next_rd = m_rd;
      case (m_rd)
        0: if (cpu_req && !cpu_we) next_rd = 1;
        1: if (q_empty) next_rd = 2;
        2: if (!vid_req) next_rd = 3;
        default: next_rd = 0;
      endcase
      if (vid_req) begin
        m_vid = m_ram[vid_addr];
      end else if (m_rd == 2) begin
        m_rdval = m_ram[cpu_addr];
      end else if (!q_empty) begin
        m_ram[q_addr[0]] = q_data[0];
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (e_wr_acc) begin
        q_addr.push_back(cpu_addr);
        q_data.push_back(cpu_wdata);
      end
      if (e_rd_done) m_rdata = m_rdval;
      m_rd = next_rd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vr, input logic [10:0] va, input logic cr,
                       input logic cw, input logic [10:0] ca, input logic [15:0] cd);
    vid_req   = vr;
    vid_addr  = va;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
  endtask

  task automatic test_reset();
    model_reset();
    settle();
    vectors++; if (wfifo_level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", wfifo_level); end
    vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
    vectors++; if (vid_data !== 16'h0000) begin miscompares++; $display("FAIL reset_vid: got %h want 0000", vid_data); end
    vectors++; if (cpu_rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_rdata: got %h want 0000", cpu_rdata); end
    advance();
    reset = 1'b1;
    drive(0, 11'd10, 1, 1, 11'd10, 16'h1111);
    settle();
    vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_prewrite_ready: got %b want 1", cpu_ready); end
    advance();
    drive(0, 11'd10, 0, 0, 11'd0, 16'h0);
    repeat (2) begin settle(); advance(); end
    drive(1, 11'd10, 1, 1, 11'd10, 16'h2222);
    settle(); advance();
    drive(1, 11'd10, 1, 1, 11'd11, 16'h3333);
    settle(); advance();
    cpu_req = 1'b0;
    settle();
    vectors++; if (wfifo_level !== 3'd2 || e_level !== 3'd2) begin miscompares++; $display("FAIL reset_queued_level: got %0d want 2", wfifo_level); end
    @(posedge clk); #1;
    reset   = 1'b0;
    vid_req = 1'b0;
    model_reset();
    settle();
    vectors++; if (wfifo_level !== 3'd0) begin miscompares++; $display("FAIL reset_flush_level: got %0d want 0", wfifo_level); end
    vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_flush_ready: got %b want 0", cpu_ready); end
    vectors++; if (vid_data !== 16'h0000) begin miscompares++; $display("FAIL reset_flush_vid: got %h want 0000", vid_data); end
    advance();
    reset = 1'b1;
    repeat (3) begin
      settle();
      vectors++; if (wfifo_level !== e_level) begin miscompares++; $display("FAIL reset_idle_level: got %0d want %0d", wfifo_level, e_level); end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      vid_req = (i < 2);
      settle();
      vectors++; if (vid_data !== e_vid) begin miscompares++; $display("FAIL reset_vid_model: got %h want %h", vid_data, e_vid); end
      if (i >= 1) begin
        vectors++; if (vid_data !== 16'h1111) begin miscompares++; $display("FAIL reset_discarded_write: got %h want 1111", vid_data); end
      end
      advance();
    end
  endtask

  task automatic test_video();
    drive(0, 11'd5, 1, 1, 11'd5, 16'h0741);
    settle();
    vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL video_write_ready: got %b want 1", cpu_ready); end
    advance();
    cpu_req = 1'b0;
    settle(); advance();
    for (int i = 0; i < 16; i++) begin
      vid_req = (i < 2);
      settle();
      vectors++; if (vid_data !== e_vid) begin miscompares++; $display("FAIL video_model: cycle %0d got %h want %h", i, vid_data, e_vid); end
      if (i >= 1) begin
        vectors++; if (vid_data !== 16'h0741) begin miscompares++; $display("FAIL video_held: cycle %0d got %h want 0741", i, vid_data); end
      end
      advance();
    end
  endtask

  task automatic test_fifo_full();
    logic [10:0] addrs [5];
    logic [15:0] datas [5];
    addrs = '{11'd30, 11'd31, 11'd30, 11'd32, 11'd33};
    datas = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, 16'hE4E4};
    for (int k = 0; k < 4; k++) begin
      drive(1, 11'd5, 1, 1, addrs[k], datas[k]);
      settle();
      vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL full_fill_ready: write %0d got %b want 1", k, cpu_ready); end
      vectors++; if (wfifo_level !== 3'(k)) begin miscompares++; $display("FAIL full_fill_level: write %0d got %0d want %0d", k, wfifo_level, k); end
      advance();
    end
    drive(1, 11'd5, 1, 1, addrs[4], datas[4]);
    repeat (2) begin
      settle();
      vectors++; if (cpu_ready !== 1'b0 || wfifo_level !== 3'd4) begin miscompares++; $display("FAIL full_blocked: got ready %b level %0d want 0 4", cpu_ready, wfifo_level); end
      advance();
    end
    vid_req = 1'b0;
    settle();
    vectors++; if (cpu_ready !== 1'b0 || wfifo_level !== 3'd4) begin miscompares++; $display("FAIL full_pop_no_push: got ready %b level %0d want 0 4", cpu_ready, wfifo_level); end
    advance();
    vid_req = 1'b1;
    settle();
    vectors++; if (cpu_ready !== 1'b1 || wfifo_level !== 3'd3) begin miscompares++; $display("FAIL full_after_pop: got ready %b level %0d want 1 3", cpu_ready, wfifo_level); end
    advance();
    drive(0, 11'd30, 0, 0, 11'd0, 16'h0);
    settle();
    vectors++; if (wfifo_level !== 3'd4) begin miscompares++; $display("FAIL full_refilled: got %0d want 4", wfifo_level); end
    advance();
    for (int i = 0; i < 8; i++) begin
      vid_req = (i >= 5 && i < 7);
      settle();
      vectors++; if (wfifo_level !== e_level) begin miscompares++; $display("FAIL full_drain_level: got %0d want %0d", wfifo_level, e_level); end
      if (i == 7) begin
        vectors++; if (vid_data !== 16'hC2C2) begin miscompares++; $display("FAIL full_write_order: got %h want c2c2", vid_data); end
      end
      advance();
    end
  endtask

  task automatic test_read_after_write();
    int first_ready;
    int ready_cycles;
    first_ready  = -1;
    ready_cycles = 0;
    drive(0, 11'd0, 1, 1, 11'd1199, 16'hBEEF);
    settle(); advance();
    drive(0, 11'd0, 1, 0, 11'd1199, 16'h0);
    for (int i = 0; i < 8; i++) begin
      settle();
      vectors++; if (cpu_ready !== e_ready) begin miscompares++; $display("FAIL raw_ready: cycle %0d got %b want %b", i, cpu_ready, e_ready); end
      if (cpu_ready === 1'b1) begin
        ready_cycles++;
        if (first_ready < 0) first_ready = i;
        vectors++; if (cpu_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL raw_rdata: got %h want beef", cpu_rdata); end
      end
      advance();
      if (e_rd_done) cpu_req = 1'b0;
    end
    vectors++; if (first_ready != 3 || ready_cycles != 1) begin miscompares++; $display("FAIL raw_latency: got first %0d count %0d want 3 1", first_ready, ready_cycles); end
  endtask

  task automatic test_read_vs_video();
    int first_ready;
    first_ready = -1;
    drive(0, 11'd1199, 1, 0, 11'd1199, 16'h0);
    for (int i = 0; i < 8; i++) begin
      vid_req = (i == 2 || i == 3);
      settle();
      vectors++; if (cpu_ready !== e_ready || cpu_rdata !== e_rdata) begin miscompares++; $display("FAIL rvv_model: cycle %0d got %b/%h want %b/%h", i, cpu_ready, cpu_rdata, e_ready, e_rdata); end
      if (i == 3) begin
        vectors++; if (vid_data !== 16'hBEEF) begin miscompares++; $display("FAIL rvv_vid: got %h want beef", vid_data); end
      end
      if (cpu_ready === 1'b1 && first_ready < 0) first_ready = i;
      advance();
      if (e_rd_done) cpu_req = 1'b0;
    end
    vectors++; if (first_ready != 5) begin miscompares++; $display("FAIL rvv_latency: got %0d want 5", first_ready); end
  endtask

  task automatic test_random();
    bit done;
    for (int a = 0; a < 16; a++) begin
      drive(0, 11'd0, 1, 1, 11'(a), 16'($urandom));
      settle();
      vectors++; if (cpu_ready !== e_ready) begin miscompares++; $display("FAIL rnd_prefill_ready: got %b want %b", cpu_ready, e_ready); end
      advance();
    end
    cpu_req = 1'b0;
    for (int cyc = 0; cyc < 480; cyc++) begin
      vid_req = ((cyc % 16) < 2);
      if ((cyc % 16) == 0) vid_addr = 11'($urandom_range(0, 15));
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 11'($urandom_range(0, 15));
        cpu_wdata = 16'($urandom);
      end
      settle();
      vectors++; if (cpu_ready !== e_ready) begin miscompares++; $display("FAIL rnd_ready: cycle %0d got %b want %b", cyc, cpu_ready, e_ready); end
      vectors++; if (wfifo_level !== e_level) begin miscompares++; $display("FAIL rnd_level: cycle %0d got %0d want %0d", cyc, wfifo_level, e_level); end
      vectors++; if (vid_data !== e_vid) begin miscompares++; $display("FAIL rnd_vid: cycle %0d got %h want %h", cyc, vid_data, e_vid); end
      vectors++; if (cpu_rdata !== e_rdata) begin miscompares++; $display("FAIL rnd_rdata: cycle %0d got %h want %h", cyc, cpu_rdata, e_rdata); end
      done = e_ready;
      advance();
      if (done) cpu_req = 1'b0;
    end
    drive(0, 11'd0, 0, 0, 11'd0, 16'h0);
    repeat (8) begin settle(); advance(); end
    settle();
    vectors++; if (wfifo_level !== 3'd0) begin miscompares++; $display("FAIL rnd_final_level: got %0d want 0", wfifo_level); end
  endtask

  initial begin
    test_reset();
    test_video();
    test_fifo_full();
    test_read_after_write();
    test_read_vs_video();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
